// File: rtl/pool_pkg.sv
// Shared types and helpers for the frame-level accumulator arbiter.
package pool_pkg;

  localparam int DEFAULT_COUNT_BITS = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } arb_state_t;

  // Width of a requester id; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational search: first set bit of req at or after ptr, wrapping past N-1 to 0.
module rr_picker
  import pool_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = id_width(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic           found,
  output logic [IDW-1:0] idx
);

  logic [2*N-1:0] req_dbl;
  logic [N-1:0]   rot;
  int             pos;

  // Duplicating the vector turns the wrap-around into a plain slice.
  assign req_dbl = {req, req};

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_rot
      assign rot[gi] = req_dbl[int'(ptr) + gi];
    end
  endgenerate

  always_comb begin
    found = 1'b0;
    pos   = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        pos   = int'(ptr) + i;
      end
    end
    if (pos >= N) begin
      pos = pos - N;
    end
    idx = IDW'(pos);
  end

endmodule

// File: rtl/pool_arbiter.sv
// Frame-level arbiter sharing one global-sum accumulator between REQUESTERS pixel streams.
// Define POOL_ARB_FIXED_PRIO_EN for lowest-index-wins priority instead of round-robin.
module pool_arbiter
  import pool_pkg::*;
#(
  parameter int REQUESTERS = 4,
  parameter int VALUE_BITS = 32,
  parameter int CHANNELS   = 8,
  parameter int COUNT_BITS = DEFAULT_COUNT_BITS
) (
  input  logic                                                  clk,
  input  logic                                                  reset,
  input  logic [REQUESTERS-1:0][CHANNELS-1:0][VALUE_BITS-1:0]   req_data,
  input  logic [REQUESTERS-1:0]                                 req_valid,
  output logic [REQUESTERS-1:0]                                 req_ready,
  input  logic [REQUESTERS-1:0]                                 req_last,
  output logic [CHANNELS-1:0][VALUE_BITS-1:0]                   acc_i_data,
  output logic                                                  acc_i_valid,
  input  logic                                                  acc_i_ready,
  output logic                                                  acc_i_last,
  input  logic [CHANNELS-1:0][VALUE_BITS-1:0]                   acc_o_data,
  input  logic                                                  acc_o_valid,
  output logic                                                  acc_o_ready,
  output logic [CHANNELS-1:0][VALUE_BITS-1:0]                   o_data,
  output logic                                                  o_valid,
  input  logic                                                  o_ready,
  output logic [id_width(REQUESTERS)-1:0]                       o_id,
  output logic [COUNT_BITS-1:0]                                 o_count
);

  localparam int                    IDW       = id_width(REQUESTERS);
  localparam logic [COUNT_BITS-1:0] COUNT_MAX = '1;
  localparam logic [IDW-1:0]        LAST_ID   = IDW'(REQUESTERS - 1);

  arb_state_t            state_q, state_d;
  logic [IDW-1:0]        grant_q, grant_d;
  logic [COUNT_BITS-1:0] count_q, count_d;
  logic [IDW-1:0]        search_from;
  logic                  pick_found;
  logic [IDW-1:0]        pick_idx;
  logic                  streaming;
  logic                  beat;
  logic                  result_done;

  assign streaming   = (state_q == STREAM);
  assign beat        = streaming && req_valid[grant_q] && acc_i_ready;
  assign result_done = (state_q == DRAIN) && acc_o_valid && o_ready;

`ifdef POOL_ARB_FIXED_PRIO_EN
  assign search_from = '0;
`else
  logic [IDW-1:0] ptr_q, ptr_d;

  assign search_from = ptr_q;

  // The requester after the one just served gets first look next time.
  always_comb begin
    ptr_d = ptr_q;
    if (result_done) begin
      ptr_d = (grant_q == LAST_ID) ? '0 : grant_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  rr_picker #(
    .N   (REQUESTERS),
    .IDW (IDW)
  ) u_picker (
    .req   (req_valid),
    .ptr   (search_from),
    .found (pick_found),
    .idx   (pick_idx)
  );

  genvar gi;
  generate
    for (gi = 0; gi < REQUESTERS; gi++) begin : g_ready
      assign req_ready[gi] = streaming && (grant_q == IDW'(gi)) && acc_i_ready;
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    count_d     = count_q;
    acc_i_data  = '0;
    acc_i_valid = 1'b0;
    acc_i_last  = 1'b0;
    acc_o_ready = 1'b0;
    o_data      = '0;
    o_valid     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          count_d = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        acc_i_data  = req_data[grant_q];
        acc_i_valid = req_valid[grant_q];
        acc_i_last  = req_valid[grant_q] && req_last[grant_q];
        if (beat) begin
          if (count_q != COUNT_MAX) begin
            count_d = count_q + 1'b1;
          end
          if (req_last[grant_q]) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        o_data      = acc_o_data;
        o_valid     = acc_o_valid;
        acc_o_ready = o_ready;
        if (result_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      count_q <= count_d;
    end
  end

  assign o_id    = grant_q;
  assign o_count = count_q;

endmodule

// File: tb/tb_pool_arbiter.sv
// Self-checking bench for pool_arbiter: directed scenarios plus randomized frames and backpressure
// against a frame-level reference model and a behavioural accumulator.
module tb_pool_arbiter;
  import pool_pkg::*;

  localparam int R    = 4;
  localparam int VB   = 32;
  localparam int CH   = 4;
  localparam int CB   = 4;
  localparam int IDB  = id_width(R);
  localparam int CMAX = (1 << CB) - 1;

`ifdef POOL_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  typedef logic [CH-1:0][VB-1:0] pix_t;
  typedef enum {M_IDLE, M_STREAM, M_DRAIN} mphase_t;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [R-1:0][CH-1:0][VB-1:0] req_data;
  logic [R-1:0]         req_valid, req_ready, req_last;
  pix_t                 acc_i_data, acc_o_data, o_data;
  logic                 acc_i_valid, acc_i_ready, acc_i_last;
  logic                 acc_o_valid, acc_o_ready, o_valid, o_ready;
  logic [IDB-1:0]       o_id;
  logic [CB-1:0]        o_count;

  always #5 clk = ~clk;

  pool_arbiter #(
    .REQUESTERS (R),
    .VALUE_BITS (VB),
    .CHANNELS   (CH),
    .COUNT_BITS (CB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_data    (req_data),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_last    (req_last),
    .acc_i_data  (acc_i_data),
    .acc_i_valid (acc_i_valid),
    .acc_i_ready (acc_i_ready),
    .acc_i_last  (acc_i_last),
    .acc_o_data  (acc_o_data),
    .acc_o_valid (acc_o_valid),
    .acc_o_ready (acc_o_ready),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_ready     (o_ready),
    .o_id        (o_id),
    .o_count     (o_count)
  );

  int checks = 0;
  int errors = 0;

  // Requester pixel queues and enables
  pix_t q_data[R][$];
  bit   q_last[R][$];
  bit   en[R];

  // Behavioural accumulator
  pix_t acc_sum;
  bit   acc_full;

  // Frame-level reference model
  mphase_t ph;
  int   mptr, owner, pick, frame_beats;
  pix_t exp_data;
  int   exp_count;
  int   rdy_pct;
  int   oready_low, hold_seen;
  bit   hold_test, holding;
  int   got_ids[$];
  pix_t got_data[$];
  int   got_count[$];

  // Per-cycle handshake captures
  bit   hs_in, acc_in, acc_in_last, acc_out, hs_out;
  pix_t acc_in_data;
  logic [IDB-1:0] cap_id;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic add_frame(input int r, input int len, input bit rnd, input logic [VB-1:0] val);
    pix_t p;
    for (int i = 0; i < len; i++) begin
      for (int c = 0; c < CH; c++) p[c] = rnd ? VB'($urandom) : val;
      q_data[r].push_back(p);
      q_last[r].push_back(i == len - 1);
    end
  endtask

  task automatic clear_model();
    for (int r = 0; r < R; r++) begin
      q_data[r].delete();
      q_last[r].delete();
      en[r] = 1'b1;
    end
    acc_sum = '0; acc_full = 1'b0;
    ph = M_IDLE; mptr = 0; owner = 0; frame_beats = 0;
    oready_low = 0; hold_test = 1'b0; holding = 1'b0;
  endtask

  task automatic clear_results();
    got_ids.delete(); got_data.delete(); got_count.delete();
  endtask

  task automatic drive_inputs();
    for (int r = 0; r < R; r++) begin
      if (en[r] && q_data[r].size() > 0) begin
        req_valid[r] = 1'b1;
        req_data[r]  = q_data[r][0];
        req_last[r]  = q_last[r][0];
      end else begin
        req_valid[r] = 1'b0;
        req_data[r]  = '0;
        req_last[r]  = 1'($urandom_range(1));
      end
    end
    acc_i_ready = !acc_full && ($urandom_range(99) < rdy_pct);
    acc_o_valid = acc_full;
    acc_o_data  = acc_sum;
    holding = (oready_low > 0);
    if (holding) begin
      o_ready = 1'b0;
      oready_low--;
    end else begin
      o_ready = ($urandom_range(99) < rdy_pct);
    end
  endtask

  task automatic tick();
    logic [R-1:0] exp_rr;
    int len;
    drive_inputs();
    pick = -1;
    if (ph == M_IDLE) begin
      int start;
      start = FIXED ? 0 : mptr;
      for (int i = 0; i < R; i++) begin
        if (pick < 0 && en[(start + i) % R] && q_data[(start + i) % R].size() > 0)
          pick = (start + i) % R;
      end
    end

    @(negedge clk);
    exp_rr = '0;
    if (ph == M_STREAM && acc_i_ready) exp_rr[owner] = 1'b1;
    chk("req_ready", req_ready, exp_rr);
    chk("acc_i_valid", acc_i_valid, ph == M_STREAM && req_valid[owner]);
    chk("acc_i_last", acc_i_last, ph == M_STREAM && req_valid[owner] && req_last[owner]);
    if (ph == M_STREAM && req_valid[owner]) chk("acc_i_data", acc_i_data, req_data[owner]);
    chk("acc_o_ready", acc_o_ready, ph == M_DRAIN && o_ready);
    chk("o_valid", o_valid, ph == M_DRAIN && acc_o_valid);
    if (ph == M_DRAIN && acc_o_valid) begin
      chk("o_id", o_id, owner);
      chk("o_count", o_count, exp_count);
      chk("o_data", o_data, exp_data);
    end
    if (holding && o_valid) hold_seen++;
    hs_in       = (ph == M_STREAM) && req_valid[owner] && req_ready[owner];
    acc_in      = acc_i_valid && acc_i_ready;
    acc_in_last = acc_i_last;
    acc_in_data = acc_i_data;
    acc_out     = acc_o_valid && acc_o_ready;
    hs_out      = o_valid && o_ready;
    cap_id      = o_id;

    @(posedge clk);
    #1;
    if (hs_in) begin
      bit lst;
      lst = q_last[owner].pop_front();
      void'(q_data[owner].pop_front());
      frame_beats++;
      if (lst) ph = M_DRAIN;
    end
    if (acc_in) begin
      for (int c = 0; c < CH; c++) acc_sum[c] = acc_sum[c] + acc_in_data[c];
      if (acc_in_last) acc_full = 1'b1;
    end
    if (acc_out) begin
      acc_full = 1'b0;
      acc_sum  = '0;
    end
    if (hs_out) begin
      got_ids.push_back(int'(cap_id));
      got_data.push_back(exp_data);
      got_count.push_back(exp_count);
      mptr = (owner + 1) % R;
      ph = M_IDLE;
    end
    if (pick >= 0) begin
      owner = pick;
      ph = M_STREAM;
      frame_beats = 0;
      exp_data = '0;
      len = 0;
      for (int i = 0; i < q_data[owner].size(); i++) begin
        for (int c = 0; c < CH; c++) exp_data[c] = exp_data[c] + q_data[owner][i][c];
        len++;
        if (q_last[owner][i]) break;
      end
      exp_count = (len > CMAX) ? CMAX : len;
    end
    if (hold_test && ph == M_DRAIN) begin
      oready_low = 5;
      hold_test = 1'b0;
    end
  endtask

  function automatic bit all_done();
    for (int r = 0; r < R; r++) if (q_data[r].size() > 0) return 1'b0;
    return (ph == M_IDLE);
  endfunction

  task automatic run(input string tag, input int budget);
    int n;
    n = 0;
    while (!all_done() && n < budget) begin
      tick();
      n++;
    end
    checks++;
    assert (n < budget) else begin
      errors++;
      $error("FAIL %s_timeout: observed %0d cycles expected < %0d", tag, n, budget);
    end
  endtask

  function automatic int got_id(input int i);
    return (i < got_ids.size()) ? got_ids[i] : -1;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, '0);
    chk({tag, "_acc_i_valid"}, acc_i_valid, 1'b0);
    chk({tag, "_acc_i_last"}, acc_i_last, 1'b0);
    chk({tag, "_acc_o_ready"}, acc_o_ready, 1'b0);
    chk({tag, "_o_valid"}, o_valid, 1'b0);
    chk({tag, "_o_id"}, o_id, '0);
    chk({tag, "_o_count"}, o_count, '0);
  endtask

  task automatic idle_inputs();
    req_valid = '0; req_data = '0; req_last = '0;
    acc_i_ready = 1'b0; acc_o_valid = 1'b0; acc_o_data = '0; o_ready = 1'b0;
  endtask

  initial begin
    int exp_a[5];
    int exp_d[2];
    int exp_g[6];
    int n;
    int nf;
`ifdef POOL_ARB_FIXED_PRIO_EN
    exp_a = '{0, 0, 1, 2, 3};
    exp_d = '{0, 3};
    exp_g = '{1, 1, 1, 3, 3, 3};
`else
    exp_a = '{0, 1, 2, 3, 0};
    exp_d = '{3, 0};
    exp_g = '{1, 3, 1, 3, 1, 3};
`endif
    clear_model();
    clear_results();
    rdy_pct = 100;
    hold_seen = 0;
    idle_inputs();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b1;

    // All requesters continuously valid, 2-pixel frames
    add_frame(0, 2, 1'b1, '0); add_frame(0, 2, 1'b1, '0);
    for (int r = 1; r < R; r++) add_frame(r, 2, 1'b1, '0);
    rdy_pct = 70;
    run("all4", 500);
    chk("all4_nres", got_ids.size(), 5);
    for (int i = 0; i < 5; i++) chk($sformatf("all4_id%0d", i), got_id(i), exp_a[i]);
    $display("all4 frames: ids %p", got_ids);

    // Single requester, 4 pixels of 2.0 in Q15.16
    clear_results();
    rdy_pct = 100;
    add_frame(1, 4, 1'b0, 32'h0002_0000);
    run("single", 100);
    chk("single_id", got_id(0), 1);
    chk("single_data", (got_data.size() > 0) ? got_data[0] : '0, {CH{32'h0008_0000}});
    chk("single_count", (got_count.size() > 0) ? got_count[0] : -1, 4);
    $display("single frame: ids %p", got_ids);

    // Requester 2 appears while requester 0 is mid-frame
    clear_results();
    add_frame(0, 4, 1'b1, '0);
    add_frame(2, 3, 1'b1, '0);
    en[2] = 1'b0;
    n = 0;
    while (!(ph == M_STREAM && owner == 0 && frame_beats >= 1) && n < 20) begin
      tick();
      n++;
    end
    chk("midframe_reach", n < 20, 1'b1);
    en[2] = 1'b1;
    run("midframe", 100);
    chk("midframe_id0", got_id(0), 0);
    chk("midframe_id1", got_id(1), 2);
    $display("midframe: ids %p", got_ids);

    // o_ready held low 5 cycles in DRAIN, next requester queued behind it
    clear_results();
    add_frame(3, 3, 1'b1, '0);
    add_frame(0, 2, 1'b1, '0);
    hold_test = 1'b1;
    hold_seen = 0;
    run("hold", 100);
    chk("hold_cycles", hold_seen, 5);
    chk("hold_id0", got_id(0), exp_d[0]);
    chk("hold_id1", got_id(1), exp_d[1]);
    $display("hold: ids %p held %0d", got_ids, hold_seen);

    // Randomized frames, lengths past count saturation, random backpressure
    for (int round = 0; round < 6; round++) begin
      clear_results();
      nf = 0;
      for (int r = 0; r < R; r++) begin
        int k;
        k = $urandom_range(2);
        for (int f = 0; f < k; f++) add_frame(r, $urandom_range(1, 18), 1'b1, '0);
        nf += k;
      end
      rdy_pct = $urandom_range(40, 100);
      run("random", 4000);
      chk("random_nres", got_ids.size(), nf);
      $display("random round %0d: %0d frames, ids %p", round, nf, got_ids);
    end

    // Reset pulled mid-STREAM
    clear_results();
    rdy_pct = 100;
    add_frame(1, 8, 1'b1, '0);
    n = 0;
    while (!(ph == M_STREAM && frame_beats >= 2) && n < 50) begin
      tick();
      n++;
    end
    chk("rst_reach", n < 50, 1'b1);
    reset = 1'b0;
    #1;
    check_reset_outputs("midrst");
    clear_model();
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    for (int r = 0; r < R; r++) add_frame(r, 2, 1'b1, '0);
    run("postrst", 200);
    chk("postrst_first", got_id(0), 0);
    chk("postrst_nres", got_ids.size(), R);
    $display("post reset: ids %p", got_ids);

    // Requesters 1 and 3 continuously valid
    clear_results();
    for (int f = 0; f < 3; f++) begin
      add_frame(1, 2, 1'b1, '0);
      add_frame(3, 2, 1'b1, '0);
    end
    rdy_pct = 80;
    run("pair", 400);
    for (int i = 0; i < 6; i++) chk($sformatf("pair_id%0d", i), got_id(i), exp_g[i]);
    $display("pair 1/3: ids %p", got_ids);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pool_arbiter.md
# pool_arbiter

Frame-level round-robin arbiter that shares one global-sum accumulator between REQUESTERS pixel streams. Grants the accumulator to one requester for a whole image (through its last pixel), then waits for the accumulator's result to drain. Returns that result tagged with the requester id and the frame's pixel count, so a downstream stage can form the average. Sits between the per-branch feature streams and the accumulator in the global-pool stage.

## Interface
- REQUESTERS, 4: number of input streams (≥2)
- VALUE_BITS, 32: signed Q15.16 value width
- CHANNELS, 8: values per pixel
- COUNT_BITS, 16: pixel-count width
- clk  in  1  operating clock
- reset  in  1  asynchronous, active-low reset
- req_data  in  [REQUESTERS][CHANNELS]×VALUE_BITS signed  requester pixels
- req_valid  in  [REQUESTERS]  requester pixel valid
- req_ready  out  [REQUESTERS]  pixel accepted from requester r
- req_last  in  [REQUESTERS]  last pixel of requester's image
- acc_i_data  out  [CHANNELS]×VALUE_BITS  pixel to accumulator
- acc_i_valid  out  1  valid to accumulator
- acc_i_ready  in  1  accumulator ready
- acc_i_last  out  1  last to accumulator
- acc_o_data  in  [CHANNELS]×VALUE_BITS  accumulator result
- acc_o_valid  in  1  result valid
- acc_o_ready  out  1  result consumed
- o_data  out  [CHANNELS]×VALUE_BITS  tagged result
- o_valid  out  1  result valid
- o_ready  in  1  downstream ready
- o_id  out  $clog2(REQUESTERS)  owning requester
- o_count  out  COUNT_BITS  pixels accepted in that frame (saturating)

## Operation
- FSM states: IDLE, STREAM, DRAIN.
- IDLE:
  - Picks the first r with req_valid[r] set, searching from ptr upward with wrap-around.
  - Registers the winner as grant, clears count, moves to STREAM on the next edge.
  - No pixel is accepted in IDLE.
  - If no requester is valid, stays in IDLE.
- STREAM:
  - acc_i_data/valid/last = req_data/valid/last[grant].
  - req_ready[grant] = acc_i_ready. All other req_ready are 0.
  - acc_i_valid and acc_i_last are gated to 0 outside STREAM.
  - acc_i_last is only ever 1 together with acc_i_valid.
  - Each transfer (valid && ready) increments count, saturating at 2^COUNT_BITS−1.
  - A transfer with last moves the FSM to DRAIN.
- DRAIN:
  - o_data = acc_o_data, o_valid = acc_o_valid, acc_o_ready = o_ready.
  - o_id = grant, o_count = count.
  - On o_valid && o_ready: ptr ← grant+1 (mod REQUESTERS), state ← IDLE.
- Outside DRAIN, o_valid and acc_o_ready are 0.
- A requester that raises req_valid mid-frame of another requester waits; it cannot preempt.
- A frame's final count includes the last pixel.

## Timing
- Reset (reset=0, asynchronous): state=IDLE, ptr=0, grant=0, count=0.
  - Outputs under reset: all req_ready=0, acc_i_valid=0, acc_i_last=0, acc_o_ready=0, o_valid=0, o_id=0, o_count=0.
  - Reset release is synchronous to clk.
- Reset mid-frame drops the frame; the accumulator is reset by the same signal.
- Arbitration latency: 1 cycle from req_valid seen in IDLE to first possible acceptance.
- Streaming throughput: 1 pixel/cycle, combinational pass-through, no added pipeline stage.
- Result path is combinational. Turnaround from result handshake to the next grant is 1 cycle (IDLE).
- A single-pixel frame (valid && last on the first beat) gives count=1.
- If all requesters are continuously valid, the grant order is 0,1,2,…,REQUESTERS−1,0.

## Configuration
- POOL_ARB_FIXED_PRIO_EN
  - Defined: IDLE always searches from requester 0 (lowest index wins) and ptr is unused.
  - Undefined (default): round-robin as above.

## Structure
- Package pool_pkg holds:
  - enum arb_state_t {IDLE, STREAM, DRAIN}
  - ID width function clog2-based
  - default COUNT_BITS constant
- Sub-module rr_picker is natural: combinational "first set bit at or after ptr, with wrap". It outputs a found flag and an index.

## Test plan
- Single requester, 4-pixel frame of channel value 2.0 into a real accumulator → one result: o_data=8 per channel, o_id=that requester, o_count=4.
- All 4 requesters valid continuously, 2-pixel frames → results in o_id order 0,1,2,3,0. No req_ready is ever asserted for a non-granted requester.
- Requester 2 asserts valid mid-frame of requester 0 → requester 0 completes uninterrupted, then requester 2 is granted.
- o_ready held low 5 cycles in DRAIN → o_valid held, o_data/o_id stable, no req_ready asserted; grant advances one cycle after the handshake.
- reset pulled low mid-STREAM → all outputs 0 immediately; after release, ptr=0 and requester 0 wins first.
- POOL_ARB_FIXED_PRIO_EN defined, requesters 1 and 3 continuously valid → requester 1 granted every time.
